div_prenorm: RTL
================

DIV_PRENORM -- requirements
Module: div_prenorm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH)+1, meaning width of leading-zero and iteration counts.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 SHALL have port sign, input, 1, 1 = signed two's-complement operation, 0 = unsigned.
REQ-008 SHALL have port dividend, input, WIDTH, raw dividend.
REQ-009 SHALL have port divisor, input, WIDTH, raw divisor.
REQ-010 SHALL have port flush, input, 1, abort any in-flight operation.
REQ-011 SHALL have port out_valid, output, 1, normalised result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream divider core accepts the result.
REQ-013 SHALL have port dividend_abs, output, WIDTH, unsigned magnitude of dividend (remainder bypass path).
REQ-014 SHALL have port dividend_norm, output, WIDTH, dividend_abs shifted left by dividend_lz.
REQ-015 SHALL have port divisor_norm, output, WIDTH, divisor magnitude shifted left by divisor_lz.
REQ-016 SHALL have port dividend_lz, output, CNTW, leading zeros of dividend_abs.
REQ-017 SHALL have port divisor_lz, output, CNTW, leading zeros of divisor magnitude.
REQ-018 SHALL have port iter_cnt, output, CNTW, number of quotient iterations required.
REQ-019 SHALL have port bypass, output, 1, core iteration not required.
REQ-020 SHALL have port div_zero, output, 1, divisor is zero.
REQ-021 SHALL have port overflow, output, 1, signed MIN / -1.
REQ-022 SHALL have port q_neg, output, 1, quotient must be negated.
REQ-023 SHALL have port r_neg, output, 1, remainder must be negated.

Function
REQ-024 SHALL implement FSM states IDLE, ABS, NORM, HOLD.
REQ-025 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-026 SHALL, on transfer, capture sign, operand sign bits (sign & MSB) and magnitudes (two's-complement negate when sign bit set, else pass), then enter ABS.
REQ-027 SHALL treat magnitude of 2^(WIDTH-1) as unsigned WIDTH-bit value 1 followed by zeros.
REQ-028 SHALL in ABS compute both leading-zero counts (zero operand gives WIDTH), the overflow flag, and the div_zero flag, then enter NORM.
REQ-029 SHALL in NORM register shifted operands, iter_cnt, bypass, q_neg = dividend_sign XOR divisor_sign, r_neg = dividend_sign, then enter HOLD.
REQ-030 SHALL set iter_cnt = divisor_lz - dividend_lz + 1 when dividend_lz <= divisor_lz and no bypass condition, else 0.
REQ-031 SHALL set bypass=1 when div_zero, overflow, dividend_abs == 0, or dividend_lz > divisor_lz.
REQ-032 SHALL assert out_valid only in HOLD; outputs held stable while out_valid && !out_ready.
REQ-033 SHALL return from HOLD to IDLE on out_ready; fixed latency: out_valid asserted 3 cycles after the accepting edge.
REQ-034 SHALL, when flush=1, enter IDLE on next edge from any state, deasserting out_valid; flush has priority over a same-cycle transfer or out_ready.
REQ-035 SHALL ignore in_valid outside IDLE; no input buffering.
REQ-036 SHALL treat operands as unsigned when sign=0 (overflow, q_neg, r_neg = 0).

Reset
REQ-037 SHALL on rst=1 enter IDLE, with out_valid=0 and in_ready=1 after the edge, and all data/flag outputs 0.
REQ-038 SHALL give rst priority over flush and all handshakes; reset mid-operation discards the operation.

Verification
REQ-039 SHALL cover unsigned 100/7 -> dividend_lz=25, divisor_lz=29, dividend_norm=0xC8000000, divisor_norm=0xE0000000, iter_cnt=5, bypass=0, out_valid 3 cycles after accept.
REQ-040 SHALL cover signed -7/2 -> dividend_abs=7, dividend_lz=29, divisor_lz=30, iter_cnt=2, q_neg=1, r_neg=1.
REQ-041 SHALL cover divisor 0 (dividend 5) -> div_zero=1, bypass=1, iter_cnt=0.
REQ-042 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> overflow=1, bypass=1, dividend_abs=0x80000000, dividend_lz=0.
REQ-043 SHALL cover out_ready low 5 cycles in HOLD -> outputs unchanged, in_ready=0; out_ready high -> IDLE next cycle, in_ready=1.
REQ-044 SHALL cover flush in NORM, then rst mid-ABS -> out_valid never asserted, in_ready=1 next cycle, next operation correct.

Source files
------------

// File: rtl/div_prenorm.sv
// div_prenorm
// Divider pre-normalisation stage. It takes a raw dividend/divisor pair
// (signed or unsigned), takes the magnitudes, and counts the leading zeros
// of each magnitude. It then left-justifies both operands and works out how
// many quotient iterations the downstream divider core needs. It also flags
// the cases where the core can be skipped: divide-by-zero, signed MIN / -1,
// a zero dividend, and a dividend smaller than the divisor.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (accepted only in IDLE)
//   sign                   1 = signed two's-complement, 0 = unsigned
//   dividend, divisor      raw operands
//   flush                  abort any in-flight operation
//   out_valid / out_ready  result handshake toward the divider core
//   dividend_abs           dividend magnitude (remainder bypass path)
//   dividend_norm          dividend_abs << dividend_lz
//   divisor_norm           divisor magnitude << divisor_lz
//   dividend_lz            leading zeros of the dividend magnitude
//   divisor_lz             leading zeros of the divisor magnitude
//   iter_cnt               quotient iterations required
//   bypass                 core iteration not required
//   div_zero               divisor is zero
//   overflow               signed MIN / -1
//   q_neg, r_neg           quotient / remainder must be negated
module div_prenorm #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dividend_abs,
  output logic [WIDTH-1:0] dividend_norm,
  output logic [WIDTH-1:0] divisor_norm,
  output logic [CNTW-1:0]  dividend_lz,
  output logic [CNTW-1:0]  divisor_lz,
  output logic [CNTW-1:0]  iter_cnt,
  output logic             bypass,
  output logic             div_zero,
  output logic             overflow,
  output logic             q_neg,
  output logic             r_neg
);

  typedef enum logic [1:0] {IDLE, ABS, NORM, HOLD} state_t;

  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_MAG = WIDTH'(1);

  state_t           state, state_next;
  logic             accept;
  logic             op_signed;
  logic             dvd_sign;
  logic             dvs_sign;
  logic [WIDTH-1:0] dvs_mag;
  logic             bypass_c;

  // Leading-zero count; an all-zero value yields WIDTH.
  function automatic logic [CNTW-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [CNTW-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + CNTW'(1);
      end
    end
    return n;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Flush wins over a same-cycle transfer, so a flushed request is never captured.
  assign accept = in_valid && in_ready && !flush;

  // Any skip condition means the core has no iterations to run.
  assign bypass_c = div_zero || overflow || (dividend_abs == '0) ||
                    (dividend_lz > divisor_lz);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. The pipeline always advances IDLE->ABS->NORM->HOLD,
  // so latency is fixed. Flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ABS;
      ABS:     state_next = NORM;
      NORM:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath registers. Each stage writes only its own fields, so nothing
  // moves while the result waits in HOLD. The magnitude of MIN comes out of
  // the negate unchanged (1 followed by zeros), which is the correct unsigned
  // magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_signed     <= 1'b0;
      dvd_sign      <= 1'b0;
      dvs_sign      <= 1'b0;
      dvs_mag       <= '0;
      dividend_abs  <= '0;
      dividend_norm <= '0;
      divisor_norm  <= '0;
      dividend_lz   <= '0;
      divisor_lz    <= '0;
      iter_cnt      <= '0;
      bypass        <= 1'b0;
      div_zero      <= 1'b0;
      overflow      <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
    end else begin
      if (accept) begin
        op_signed    <= sign;
        dvd_sign     <= sign & dividend[WIDTH-1];
        dvs_sign     <= sign & divisor[WIDTH-1];
        dividend_abs <= (sign & dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag      <= (sign & divisor[WIDTH-1])  ? -divisor  : divisor;
      end
      if (state == ABS) begin
        dividend_lz <= lzc(dividend_abs);
        divisor_lz  <= lzc(dvs_mag);
        div_zero    <= (dvs_mag == '0);
        overflow    <= op_signed && dvd_sign && dvs_sign &&
                       (dividend_abs == MIN_MAG) && (dvs_mag == ONE_MAG);
      end
      if (state == NORM) begin
        dividend_norm <= dividend_abs << dividend_lz;
        divisor_norm  <= dvs_mag << divisor_lz;
        iter_cnt      <= bypass_c ? '0 : (divisor_lz - dividend_lz + CNTW'(1));
        bypass        <= bypass_c;
        q_neg         <= dvd_sign ^ dvs_sign;
        r_neg         <= dvd_sign;
      end
    end
  end

endmodule
